frac_n_modulus_controller: RTL and testbench

//  Sequences the 240/248 dual-modulus divider in the frac-N feedback path. Runs once per divider output

---
 rtl/frac_n_modulus_controller_if.sv | 34 +++
 rtl/frac_n_modulus_controller.sv | 164 ++++++++++++++++
 tb/tb_frac_n_modulus_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_n_modulus_controller_if.sv
// ============================================================================
// Module   : frac_n_modulus_controller_if
// Brief    : Config handshake and status bundle for the frac-N modulus controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frac_n_modulus_controller_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
);
  logic             enable;
  logic [ACC_W-1:0] cfg_frac;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             select_mode;
  logic [ACC_W-1:0] acc_value;
  logic [ACC_W-1:0] active_frac;
  logic             running;
  logic [CNT_W-1:0] run_cnt;

  // master = config/status owner, slave = controller
  modport master (
    output enable, cfg_frac, cfg_valid,
    input  cfg_ready, select_mode, acc_value, active_frac, running, run_cnt
  );

  modport slave (
    input  enable, cfg_frac, cfg_valid,
    output cfg_ready, select_mode, acc_value, active_frac, running, run_cnt
  );
endinterface

`default_nettype wire

// File: rtl/frac_n_modulus_controller.sv
// ============================================================================
// Module   : frac_n_modulus_controller
// Brief    : First-order accumulator sequencing a 240/248 dual-modulus divider.
//            Optional LFSR carry-in dither when FRACN_LFSR_DITHER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_n_modulus_controller #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  wire logic                    freq_in,
  input  wire logic                    reset,
  frac_n_modulus_controller_if.slave   ctl
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state,     w_state;
  logic [ACC_W-1:0] r_acc,       w_acc;
  logic [ACC_W-1:0] r_active,    w_active;
  logic [ACC_W-1:0] r_pend,      w_pend;
  logic             r_pend_vld,  w_pend_vld;
  logic             r_sel,       w_sel;
  logic [CNT_W-1:0] r_run_cnt,   w_run_cnt;

  logic [ACC_W:0]   w_sum;
  logic             w_cin;
  logic             w_capture;
  logic             w_apply_run;

`ifdef FRACN_LFSR_DITHER_EN
  localparam logic [14:0] C_LFSR_SEED = 15'h0001;

  logic [14:0] r_lfsr, w_lfsr;

  // x^15 + x^14 + 1, shifting toward the MSB
  always_comb begin
    w_lfsr = r_lfsr;
    if (r_state == S_RUN) begin
      w_lfsr = {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end
  end

  assign w_cin = r_lfsr[0];

  always_ff @(posedge freq_in or negedge reset) begin
    if (!reset) begin
      r_lfsr <= C_LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr;
    end
  end
`else
  assign w_cin = 1'b0;
`endif

  assign w_sum       = {1'b0, r_acc} + {1'b0, r_active} + {{ACC_W{1'b0}}, w_cin};
  assign w_capture   = ctl.cfg_valid & ~r_pend_vld;
  // a new word is only swapped in where the phase sequence has no partial period
  assign w_apply_run = r_pend_vld & (w_sum[ACC_W] | (r_active == '0));

  always_comb begin
    w_state    = r_state;
    w_acc      = r_acc;
    w_active   = r_active;
    w_pend     = r_pend;
    w_pend_vld = r_pend_vld;
    w_sel      = r_sel;
    w_run_cnt  = r_run_cnt;

    case (r_state)
      S_IDLE: begin
        w_sel = 1'b0;
        w_acc = '0;
        if (ctl.enable) begin
          w_state = S_START;
        end
      end

      S_START: begin
        w_acc     = '0;
        w_sel     = 1'b0;
        w_run_cnt = '0;
        if (r_pend_vld) begin
          w_active   = r_pend;
          w_pend_vld = 1'b0;
        end
        w_state = ctl.enable ? S_RUN : S_IDLE;
      end

      S_RUN: begin
        if (!ctl.enable) begin
          w_state = S_IDLE;
          w_sel   = 1'b0;
          w_acc   = '0;
        end else begin
          w_acc = w_sum[ACC_W-1:0];
          w_sel = w_sum[ACC_W];
          if (!(&r_run_cnt)) begin
            w_run_cnt = r_run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (w_apply_run) begin
            w_active   = r_pend;
            w_pend_vld = 1'b0;
          end
        end
      end

      default: begin
        w_state = S_IDLE;
        w_sel   = 1'b0;
        w_acc   = '0;
      end
    endcase

    // capture needs an empty slot, so it can never coincide with an apply
    if (w_capture) begin
      w_pend     = ctl.cfg_frac;
      w_pend_vld = 1'b1;
    end
  end

  always_ff @(posedge freq_in or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge freq_in or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_sel      <= 1'b0;
      r_run_cnt  <= '0;
    end else begin
      r_acc      <= w_acc;
      r_active   <= w_active;
      r_pend     <= w_pend;
      r_pend_vld <= w_pend_vld;
      r_sel      <= w_sel;
      r_run_cnt  <= w_run_cnt;
    end
  end

  assign ctl.cfg_ready   = ~r_pend_vld;
  assign ctl.select_mode = r_sel;
  assign ctl.acc_value   = r_acc;
  assign ctl.active_frac = r_active;
  assign ctl.running     = (r_state == S_RUN);
  assign ctl.run_cnt     = r_run_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frac_n_modulus_controller.sv
// ============================================================================
// Module   : tb_frac_n_modulus_controller
// Brief    : Self-checking bench: cycle scoreboard plus table of fractional words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_frac_n_modulus_controller;

  localparam int ACC_W = 16;
  localparam int CNT_W = 16;

  logic freq_in = 1'b0;
  logic reset   = 1'b0;

  frac_n_modulus_controller_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  frac_n_modulus_controller #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .freq_in (freq_in),
    .reset   (reset),
    .ctl     (bus)
  );

  always #5 freq_in = ~freq_in;

  typedef struct packed {
    logic        sel;
    logic [15:0] acc;
    logic [15:0] active;
    logic        ready;
    logic        running;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic [15:0] frac;
    int          n;
    int          exp_ones;
    int          exp_first;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  int          m_state;
  logic [15:0] m_acc, m_active, m_pend, m_cnt;
  logic        m_pvld, m_sel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.sel     = bus.select_mode;
    o.acc     = bus.acc_value;
    o.active  = bus.active_frac;
    o.ready   = bus.cfg_ready;
    o.running = bus.running;
    o.cnt     = bus.run_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_acc = '0; m_active = '0; m_pend = '0; m_cnt = '0;
    m_pvld = 1'b0; m_sel = 1'b0;
    exp_q.delete();
  endtask

  // expected state after the coming edge, from the inputs currently driven
  task automatic model_step();
    obs_t e;
    int   sum;
    logic cap;
    cap = bus.cfg_valid && !m_pvld;
    case (m_state)
      0: begin
        m_sel = 1'b0; m_acc = '0;
        if (bus.enable) m_state = 1;
      end
      1: begin
        m_acc = '0; m_sel = 1'b0; m_cnt = '0;
        if (m_pvld) begin m_active = m_pend; m_pvld = 1'b0; end
        m_state = bus.enable ? 2 : 0;
      end
      default: begin
        if (!bus.enable) begin
          m_state = 0; m_sel = 1'b0; m_acc = '0;
        end else begin
          sum = int'(m_acc) + int'(m_active);
          if (m_pvld && (sum >= 65536 || m_active == 16'h0000)) begin
            m_active = m_pend; m_pvld = 1'b0;
          end
          m_sel = (sum >= 65536);
          m_acc = sum[15:0];
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
        end
      end
    endcase
    if (cap) begin m_pend = bus.cfg_frac; m_pvld = 1'b1; end
    e.sel = m_sel; e.acc = m_acc; e.active = m_active;
    e.ready = !m_pvld; e.running = (m_state == 2); e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    obs_t e;
    model_step();
    @(posedge freq_in);
    #1;
    e = exp_q.pop_front();
    check("cycle", 64'(observe()), 64'(e));
  endtask

  vec_t vecs[7];

  initial begin
    int   ones, first, per;
    logic s1, s2;

    vecs[0] = '{16'h8000,   16,  8,  2};
    vecs[1] = '{16'h4000,   16,  4,  4};
    vecs[2] = '{16'hC000,    8,  6,  2};
    vecs[3] = '{16'h1000,   64,  4, 16};
    vecs[4] = '{16'h0000, 1000,  0,  0};
    vecs[5] = '{16'hFFFF,  100, 99,  2};
    vecs[6] = '{16'h0001,   10,  0,  0};

    bus.enable = 1'b0; bus.cfg_frac = '0; bus.cfg_valid = 1'b0;
    model_reset();

    // reset held over two edges
    repeat (2) @(posedge freq_in);
    #1;
    check("rst_sel",     64'(bus.select_mode), 64'd0);
    check("rst_acc",     64'(bus.acc_value),   64'd0);
    check("rst_ready",   64'(bus.cfg_ready),   64'd1);
    check("rst_running", 64'(bus.running),     64'd0);
    check("rst_cnt",     64'(bus.run_cnt),     64'd0);
    check("rst_active",  64'(bus.active_frac), 64'd0);
    reset = 1'b1;
    repeat (3) tick();

    // half-rate word: alternating moduli, 488 input clocks per two periods
    bus.cfg_frac = 16'h8000; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    check("ready_drop", 64'(bus.cfg_ready), 64'd0);
    bus.enable = 1'b1;
    tick(); tick();
    tick(); s1 = bus.select_mode;
    tick(); s2 = bus.select_mode;
    check("half_pattern", 64'({s1, s2}), 64'b01);
    per = (s1 ? 240 : 248) + (s2 ? 240 : 248);
    check("two_periods", 64'(per), 64'd488);
    bus.enable = 1'b0;
    tick();

    // table of fractional words
    for (int i = 0; i < 7; i++) begin
      bus.cfg_frac = vecs[i].frac; bus.cfg_valid = 1'b1;
      tick();
      bus.cfg_valid = 1'b0; bus.enable = 1'b1;
      tick(); tick();
      ones = 0; first = 0;
      for (int k = 1; k <= vecs[i].n; k++) begin
        tick();
        if (bus.select_mode) begin
          ones++;
          if (first == 0) first = k;
        end
      end
      check($sformatf("ones_%0d", i),  64'(ones),  64'(vecs[i].exp_ones));
      check($sformatf("first_%0d", i), 64'(first), 64'(vecs[i].exp_first));
      check($sformatf("cnt_%0d", i),   64'(bus.run_cnt), 64'(vecs[i].n));
      bus.enable = 1'b0;
      tick();
    end

    // reload while running: held until the accumulator wraps, second word stalls
    bus.cfg_frac = 16'h4000; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.enable = 1'b1;
    tick(); tick();
    tick();
    bus.cfg_frac = 16'hC000; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_frac = 16'h2222;
    check("reload_ready", 64'(bus.cfg_ready), 64'd0);
    tick();
    check("hold_before_wrap", 64'(bus.active_frac), 64'h4000);
    check("stall_ready",      64'(bus.cfg_ready),   64'd0);
    tick();
    check("apply_on_wrap", 64'({bus.select_mode, bus.active_frac}), 64'h1_C000);
    tick();
    bus.cfg_valid = 1'b0;
    check("second_captured", 64'(bus.cfg_ready), 64'd0);
    tick();
    check("second_applied", 64'(bus.active_frac), 64'h2222);
    bus.enable = 1'b0;
    tick();

    // zero word running: a pending word applies on the very next RUN edge
    bus.cfg_frac = 16'h0000; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.enable = 1'b1;
    repeat (5) tick();
    bus.cfg_frac = 16'h4000; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    check("zero_apply", 64'(bus.active_frac), 64'h4000);
    repeat (6) tick();
    bus.cfg_frac = 16'h1111; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    tick();

    // asynchronous reset between edges
    #3;
    reset = 1'b0;
    #1;
    check("async_sel",     64'(bus.select_mode), 64'd0);
    check("async_acc",     64'(bus.acc_value),   64'd0);
    check("async_cnt",     64'(bus.run_cnt),     64'd0);
    check("async_ready",   64'(bus.cfg_ready),   64'd1);
    check("async_running", 64'(bus.running),     64'd0);
    check("async_active",  64'(bus.active_frac), 64'd0);
    model_reset();
    bus.enable = 1'b0;
    @(posedge freq_in);
    #1;
    reset = 1'b1;
    repeat (2) tick();
    bus.enable = 1'b1;
    repeat (4) tick();
    check("post_reset_active", 64'(bus.active_frac), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
